alu_op_issue: RTL and testbench

- ID/EX-boundary control block that decodes MIPS opcode/funct/rt into the 4-bit ALUControl code consumed by the 32-bit ALU.
- Registers the decoded code and its operand-select flags toward EX, with a valid/ready handshake, stall and flush.
- Holds a multi-cycle `mul` in EX for MUL_CYCLES cycles, back-pressuring ID until the ALU's 64-bit product is final.

---
 rtl/alu_op_issue.sv | 266 ++++++++++++++++++++++++++
 tb/tb_alu_op_issue.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_issue.sv
// -----------------------------------------------------------------------------
// alu_op_issue
//
// ID/EX-boundary control block. Decodes the MIPS opcode/funct/rt fields into
// the 4-bit ALUControl code used by the 32-bit ALU. Registers that code and
// its operand-select flags into the EX slot. A `mul` is held in EX for
// MUL_CYCLES cycles while the ALU's 64-bit product settles.
//
// Handshake: an instruction transfers on a rising Clk edge where
// InValid & InReady are both 1. While InReady is 0, ID must keep the
// instruction (and InValid) stable; nothing is consumed.
//
// Optional feature: define ALU_OP_ISSUE_BRANCH_EN to decode beq/bne/bgtz/bltz
// into compare ops. When it is undefined, those opcodes decode as illegal.
//
// Parameters:
//   MUL_CYCLES    total cycles a mul occupies the EX slot (>= 1)
//   ILLEGAL_CODE  ALUControl value emitted for undecodable instructions
//
// Ports:
//   Clk          system clock, rising edge
//   Reset        asynchronous, active-high reset
//   InValid      ID presents a valid instruction
//   InReady      block accepts the instruction this cycle (combinational)
//   Opcode       instr[31:26]
//   Funct        instr[5:0]
//   Rt           instr[20:16], used only for REGIMM (bltz)
//   Stall        EX stalled; every register holds
//   Flush        kill the op in EX (branch/jump redirect)
//   OutValid     EX slot holds a valid op
//   ALUControl   op code to the ALU
//   ALUSrcShamt  ALU B operand = shamt (sll/srl)
//   ALUSrcImm    ALU B operand = extended immediate
//   Illegal      instruction in EX was not decodable
//   MulBusy      mul in EX, product not yet final (this is the FSM state
//                view: MulBusy == (state == BUSY))
// -----------------------------------------------------------------------------
module alu_op_issue #(
    parameter int          MUL_CYCLES   = 3,
    parameter logic [3:0]  ILLEGAL_CODE = 4'b1111
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       InValid,
    output logic       InReady,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic [4:0] Rt,
    input  logic       Stall,
    input  logic       Flush,
    output logic       OutValid,
    output logic [3:0] ALUControl,
    output logic       ALUSrcShamt,
    output logic       ALUSrcImm,
    output logic       Illegal,
    output logic       MulBusy
);

    // ALU op codes
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_MUL = 4'b0011;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SLT = 4'b1100;
    localparam logic [3:0] ALU_SGT = 4'b1101;

    // Opcodes
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_SPEC2  = 6'h1C;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    // Count register only needs to hold MUL_CYCLES-1.
    localparam int            CW       = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] count;

    // Combinational decode results
    logic [3:0] dec_code;
    logic       dec_shamt;
    logic       dec_imm;
    logic       dec_illegal;
    logic       dec_mul;

    // Rt feeds only the optional REGIMM decode; keep it referenced in
    // every build.
    logic unused_rt;
    assign unused_rt = ^Rt;

    always_comb begin
        dec_code    = ILLEGAL_CODE;
        dec_shamt   = 1'b0;
        dec_imm     = 1'b0;
        dec_illegal = 1'b1;
        dec_mul     = 1'b0;
        unique case (Opcode)
            OP_RTYPE: begin
                dec_illegal = 1'b0;
                case (Funct)
                    6'h20, 6'h21: dec_code = ALU_ADD;
                    6'h22:        dec_code = ALU_SUB;
                    6'h24:        dec_code = ALU_AND;
                    6'h25:        dec_code = ALU_OR;
                    6'h26:        dec_code = ALU_XOR;
                    6'h27:        dec_code = ALU_NOR;
                    6'h2A:        dec_code = ALU_SLT;
                    6'h00: begin
                        dec_code  = ALU_SLL;
                        dec_shamt = 1'b1;
                    end
                    6'h02: begin
                        dec_code  = ALU_SRL;
                        dec_shamt = 1'b1;
                    end
                    default: begin
                        dec_code    = ILLEGAL_CODE;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
            OP_SPEC2: begin
                if (Funct == 6'h02) begin
                    dec_code    = ALU_MUL;
                    dec_illegal = 1'b0;
                    dec_mul     = 1'b1;
                end
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
                dec_code    = ALU_ADD;
                dec_imm     = 1'b1;
                dec_illegal = 1'b0;
            end
            OP_ANDI: begin
                dec_code    = ALU_AND;
                dec_imm     = 1'b1;
                dec_illegal = 1'b0;
            end
            OP_ORI: begin
                dec_code    = ALU_OR;
                dec_imm     = 1'b1;
                dec_illegal = 1'b0;
            end
            OP_XORI: begin
                dec_code    = ALU_XOR;
                dec_imm     = 1'b1;
                dec_illegal = 1'b0;
            end
            OP_SLTI: begin
                dec_code    = ALU_SLT;
                dec_imm     = 1'b1;
                dec_illegal = 1'b0;
            end
`ifdef ALU_OP_ISSUE_BRANCH_EN
            OP_BEQ, OP_BNE: begin
                dec_code    = ALU_SUB;
                dec_illegal = 1'b0;
            end
            OP_BGTZ: begin
                dec_code    = ALU_SGT;
                dec_illegal = 1'b0;
            end
            OP_REGIMM: begin
                // Only bltz (rt == 0) is decoded; other REGIMM forms are illegal.
                if (Rt == 5'd0) begin
                    dec_code    = ALU_SLT;
                    dec_illegal = 1'b0;
                end
            end
`else
            // Branch decode disabled: these stay illegal.
            OP_BEQ, OP_BNE, OP_BGTZ, OP_REGIMM: begin
                dec_code    = ILLEGAL_CODE;
                dec_illegal = 1'b1;
            end
`endif
            default: begin
                dec_code    = ILLEGAL_CODE;
                dec_illegal = 1'b1;
            end
        endcase
    end

    assign InReady = (state == IDLE) & ~Stall & ~Flush;
    assign MulBusy = (state == BUSY);

    // Priority: Reset > Flush > Stall > accept/bubble.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            count       <= '0;
            OutValid    <= 1'b0;
            ALUControl  <= 4'b0000;
            ALUSrcShamt <= 1'b0;
            ALUSrcImm   <= 1'b0;
            Illegal     <= 1'b0;
        end else if (Flush) begin
            state       <= IDLE;
            count       <= '0;
            OutValid    <= 1'b0;
            ALUControl  <= 4'b0000;
            ALUSrcShamt <= 1'b0;
            ALUSrcImm   <= 1'b0;
            Illegal     <= 1'b0;
        end else if (Stall) begin
            // hold everything
        end else begin
            unique case (state)
                IDLE: begin
                    if (InValid) begin
                        // InReady is 1 here: IDLE, no Stall, no Flush.
                        OutValid    <= 1'b1;
                        ALUControl  <= dec_code;
                        ALUSrcShamt <= dec_shamt;
                        ALUSrcImm   <= dec_imm;
                        Illegal     <= dec_illegal;
                        if (dec_mul && (MUL_CYCLES > 1)) begin
                            state <= BUSY;
                            count <= MUL_LOAD;
                        end
                    end else begin
                        OutValid    <= 1'b0;
                        ALUControl  <= 4'b0000;
                        ALUSrcShamt <= 1'b0;
                        ALUSrcImm   <= 1'b0;
                        Illegal     <= 1'b0;
                    end
                end
                BUSY: begin
                    // mul stays visible; leave BUSY so the last cycle shows
                    // OutValid=1 with MulBusy=0 (final product).
                    count <= count - CNT_ONE;
                    if (count == CNT_ONE) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_issue.sv
// -----------------------------------------------------------------------------
// tb_alu_op_issue
//
// Directed bench for alu_op_issue with the default MUL_CYCLES=3 and
// ILLEGAL_CODE=4'b1111. Branch expectations follow ALU_OP_ISSUE_BRANCH_EN.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_alu_op_issue;

    logic       Clk;
    logic       Reset;
    logic       InValid;
    logic       InReady;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic [4:0] Rt;
    logic       Stall;
    logic       Flush;
    logic       OutValid;
    logic [3:0] ALUControl;
    logic       ALUSrcShamt;
    logic       ALUSrcImm;
    logic       Illegal;
    logic       MulBusy;

    int errors = 0;
    int checks = 0;

    // expected {Illegal, ALUSrcImm, ALUSrcShamt, ALUControl}
    logic [6:0] exp_q[$];

    alu_op_issue dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .InValid     (InValid),
        .InReady     (InReady),
        .Opcode      (Opcode),
        .Funct       (Funct),
        .Rt          (Rt),
        .Stall       (Stall),
        .Flush       (Flush),
        .OutValid    (OutValid),
        .ALUControl  (ALUControl),
        .ALUSrcShamt (ALUSrcShamt),
        .ALUSrcImm   (ALUSrcImm),
        .Illegal     (Illegal),
        .MulBusy     (MulBusy)
    );

    // ---------------- clock / reset ----------------
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Compare the full EX slot against expected values.
    task automatic check_slot(input string tag, input logic valid, input logic [3:0] code,
                              input logic shamt, input logic imm, input logic ill,
                              input logic busy);
        check({tag, ".valid"}, 32'(OutValid),    32'(valid));
        check({tag, ".code"},  32'(ALUControl),  32'(code));
        check({tag, ".shamt"}, 32'(ALUSrcShamt), 32'(shamt));
        check({tag, ".imm"},   32'(ALUSrcImm),   32'(imm));
        check({tag, ".ill"},   32'(Illegal),     32'(ill));
        check({tag, ".busy"},  32'(MulBusy),     32'(busy));
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rt);
        InValid = v;
        Opcode  = op;
        Funct   = fn;
        Rt      = rt;
    endtask

    // ---------------- decode table ----------------
    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic       rand_fn;   // funct is don't-care for this opcode
        logic [4:0] rt;
        logic [6:0] exp;       // {ill, imm, shamt, code}
    } vec_t;

`ifdef ALU_OP_ISSUE_BRANCH_EN
    localparam logic [6:0] EXP_BEQ  = 7'b000_0010;
    localparam logic [6:0] EXP_BGTZ = 7'b000_1101;
    localparam logic [6:0] EXP_BLTZ = 7'b000_1100;
`else
    localparam logic [6:0] EXP_BEQ  = 7'b100_1111;
    localparam logic [6:0] EXP_BGTZ = 7'b100_1111;
    localparam logic [6:0] EXP_BLTZ = 7'b100_1111;
`endif

    localparam int NV = 26;
    vec_t vecs[NV] = '{
        '{6'h00, 6'h20, 1'b0, 5'd0, 7'b000_0000},  // add
        '{6'h00, 6'h21, 1'b0, 5'd0, 7'b000_0000},  // addu
        '{6'h00, 6'h22, 1'b0, 5'd0, 7'b000_0010},  // sub
        '{6'h00, 6'h24, 1'b0, 5'd0, 7'b000_0100},  // and
        '{6'h00, 6'h25, 1'b0, 5'd0, 7'b000_0101},  // or
        '{6'h00, 6'h26, 1'b0, 5'd0, 7'b000_0110},  // xor
        '{6'h00, 6'h27, 1'b0, 5'd0, 7'b000_0111},  // nor
        '{6'h00, 6'h00, 1'b0, 5'd0, 7'b001_1000},  // sll
        '{6'h00, 6'h02, 1'b0, 5'd0, 7'b001_1001},  // srl
        '{6'h00, 6'h2A, 1'b0, 5'd0, 7'b000_1100},  // slt
        '{6'h00, 6'h03, 1'b0, 5'd0, 7'b100_1111},  // unknown funct
        '{6'h1C, 6'h00, 1'b0, 5'd0, 7'b100_1111},  // SPECIAL2, not mul
        '{6'h08, 6'h00, 1'b1, 5'd0, 7'b010_0000},  // addi
        '{6'h09, 6'h00, 1'b1, 5'd0, 7'b010_0000},  // addiu
        '{6'h0C, 6'h00, 1'b1, 5'd0, 7'b010_0100},  // andi
        '{6'h0D, 6'h00, 1'b1, 5'd0, 7'b010_0101},  // ori
        '{6'h0E, 6'h00, 1'b1, 5'd0, 7'b010_0110},  // xori
        '{6'h0A, 6'h00, 1'b1, 5'd0, 7'b010_1100},  // slti
        '{6'h23, 6'h00, 1'b1, 5'd0, 7'b010_0000},  // lw
        '{6'h2B, 6'h00, 1'b1, 5'd0, 7'b010_0000},  // sw
        '{6'h3F, 6'h00, 1'b1, 5'd0, 7'b100_1111},  // unknown opcode
        '{6'h04, 6'h00, 1'b1, 5'd3, EXP_BEQ},      // beq
        '{6'h05, 6'h00, 1'b1, 5'd3, EXP_BEQ},      // bne
        '{6'h07, 6'h00, 1'b1, 5'd0, EXP_BGTZ},     // bgtz
        '{6'h01, 6'h00, 1'b1, 5'd0, EXP_BLTZ},     // bltz
        '{6'h01, 6'h00, 1'b1, 5'd1, 7'b100_1111}   // bgez: never decoded
    };

    // ---------------- main sequence ----------------
    initial begin
        logic [6:0] e;
        logic [5:0] fn;

        Reset = 1'b1;
        Stall = 1'b0;
        Flush = 1'b0;
        drive(1'b0, 6'h00, 6'h00, 5'd0);
        #12;
        Reset = 1'b0;
        tick();

        // reset state
        check_slot("reset", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset.ready", 32'(InReady), 32'd1);

        // sub, then bubble
        drive(1'b1, 6'h00, 6'h22, 5'd0);
        tick();
        drive(1'b0, 6'h00, 6'h00, 5'd0);
        check_slot("sub", 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_slot("bubble", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // back-to-back decode sweep
        for (int i = 0; i < NV; i++) begin
            fn = vecs[i].rand_fn ? 6'($urandom_range(0, 63)) : vecs[i].fn;
            drive(1'b1, vecs[i].op, fn, vecs[i].rt);
            exp_q.push_back(vecs[i].exp);
            tick();
            e = exp_q.pop_front();
            check_slot($sformatf("dec%0d_op%02h", i, vecs[i].op), 1'b1, e[3:0], e[4], e[5], e[6], 1'b0);
        end
        drive(1'b0, 6'h00, 6'h00, 5'd0);
        tick();
        check("sweep_end.valid", 32'(OutValid), 32'd0);

        // mul with a second instruction waiting
        drive(1'b1, 6'h1C, 6'h02, 5'd0);
        tick();
        drive(1'b1, 6'h00, 6'h25, 5'd0);  // or, held by ID
        check_slot("mul_c1", 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b1);
        check("mul_c1.ready", 32'(InReady), 32'd0);
        tick();
        check_slot("mul_c2", 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b1);
        check("mul_c2.ready", 32'(InReady), 32'd0);
        tick();
        check_slot("mul_c3", 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mul_c3.ready", 32'(InReady), 32'd1);
        tick();
        drive(1'b0, 6'h00, 6'h00, 5'd0);
        check_slot("mul_next", 1'b1, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("mul_after.valid", 32'(OutValid), 32'd0);

        // sll then two stall cycles; an add offered during stall is not taken
        drive(1'b1, 6'h00, 6'h00, 5'd0);
        tick();
        check_slot("sll_c1", 1'b1, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0);
        Stall = 1'b1;
        drive(1'b1, 6'h00, 6'h20, 5'd0);
        #1;
        check("stall.ready", 32'(InReady), 32'd0);
        for (int s = 0; s < 2; s++) begin
            tick();
            check_slot($sformatf("sll_stall%0d", s), 1'b1, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0);
            check($sformatf("stall%0d.ready", s), 32'(InReady), 32'd0);
        end
        Stall = 1'b0;
        drive(1'b0, 6'h00, 6'h00, 5'd0);
        tick();
        check_slot("post_stall", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // mul stalled while BUSY keeps MulBusy and the count
        drive(1'b1, 6'h1C, 6'h02, 5'd0);
        tick();
        drive(1'b0, 6'h00, 6'h00, 5'd0);
        Stall = 1'b1;
        tick();
        check_slot("mul_stall", 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b1);
        Stall = 1'b0;
        tick();
        check_slot("mul_stall_c2", 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_slot("mul_stall_c3", 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("mul_stall_end.valid", 32'(OutValid), 32'd0);

        // flush in cycle 1 of a mul
        drive(1'b1, 6'h1C, 6'h02, 5'd0);
        tick();
        drive(1'b0, 6'h00, 6'h00, 5'd0);
        check("flush_pre.busy", 32'(MulBusy), 32'd1);
        Flush = 1'b1;
        #1;
        check("flush.ready", 32'(InReady), 32'd0);
        tick();
        Flush = 1'b0;
        #1;
        check_slot("flush", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        check("flush.ready_after", 32'(InReady), 32'd1);

        // reset asynchronously while BUSY
        drive(1'b1, 6'h1C, 6'h02, 5'd0);
        tick();
        drive(1'b0, 6'h00, 6'h00, 5'd0);
        check("rst_pre.busy", 32'(MulBusy), 32'd1);
        #2;
        Reset = 1'b1;
        #1;
        check_slot("async_rst", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        Reset = 1'b0;
        #1;
        check("rst_rel.ready", 32'(InReady), 32'd1);
        tick();
        check_slot("rst_rel", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // beq directed
        drive(1'b1, 6'h04, 6'h00, 5'd2);
        tick();
        drive(1'b0, 6'h00, 6'h00, 5'd0);
        check_slot("beq", 1'b1, EXP_BEQ[3:0], 1'b0, 1'b0, EXP_BEQ[6], 1'b0);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
